// File: rtl/ov7670_capture_downsampler_if.sv
// ov7670_capture_downsampler_if: camera byte stream in, capture BRAM write port out.
interface ov7670_capture_downsampler_if #(
    parameter int ADDR_WIDTH = 17
) ();
    logic                  cam_vsync;
    logic                  cam_href;
    logic                  cam_byte_valid;
    logic [7:0]            cam_data;
    logic [ADDR_WIDTH-1:0] capture_addr;
    logic                  capture_wren;
    logic [15:0]           pixel_out;

    modport master (
        input  cam_vsync, cam_href, cam_byte_valid, cam_data,
        output capture_addr, capture_wren, pixel_out
    );

    modport slave (
        output cam_vsync, cam_href, cam_byte_valid, cam_data,
        input  capture_addr, capture_wren, pixel_out
    );
endinterface

// File: rtl/ov7670_capture_downsampler.sv
// ov7670_capture_downsampler: assembles RGB444 camera bytes into pixels and
// writes every other pixel of every other line into the capture BRAM.
module ov7670_capture_downsampler #(
    parameter int SRC_WIDTH  = 640,
    parameter int SRC_HEIGHT = 480,
    parameter int FRAME_SIZE = 76800,
    parameter int ADDR_WIDTH = 17
) (
    input  logic clk,
    input  logic resetn,
    input  logic config_done,
    input  logic start_capture,
    ov7670_capture_downsampler_if.master bus,
    output logic frame_done,
    output logic frame_error,
    output logic busy
);
    localparam int CW = $clog2(SRC_WIDTH + 1);
    localparam int RW = $clog2(SRC_HEIGHT + 1);
    localparam logic [CW-1:0]         W_L  = CW'(SRC_WIDTH);
    localparam logic [RW-1:0]         H_L  = RW'(SRC_HEIGHT);
    localparam logic [ADDR_WIDTH-1:0] FS_L = ADDR_WIDTH'(FRAME_SIZE);
    localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(FRAME_SIZE - 1);

    typedef enum logic [1:0] {WAIT_CFG, WAIT_FRAME, ACTIVE} state_t;
    state_t state, state_nxt;

    logic                  vsync_q, href_q, phase, ovf;
    logic [3:0]            r_nib;
    logic [CW-1:0]         col, eff_col;
    logic [RW-1:0]         row;
    logic [ADDR_WIDTH-1:0] wr_count;
    logic                  vsync_fall, vsync_rise, href_rise, href_fall;
    logic                  start_frame, end_frame, byte_ok, eff_phase, keep, wr_go;

    assign vsync_fall = vsync_q & ~bus.cam_vsync;
    assign vsync_rise = ~vsync_q & bus.cam_vsync;
    assign href_rise  = ~href_q & bus.cam_href;
    assign href_fall  = href_q & ~bus.cam_href;

    always_ff @(posedge clk or negedge resetn)
        if (!resetn) state <= WAIT_CFG;
        else         state <= state_nxt;

    always_comb begin
        state_nxt = !config_done          ? WAIT_CFG
                  : state == WAIT_FRAME   ? (vsync_fall && start_capture ? ACTIVE : WAIT_FRAME)
                  : state == ACTIVE       ? (vsync_rise ? WAIT_FRAME : ACTIVE)
                  : WAIT_FRAME;
    end

    // A byte landing on the href rising edge already belongs to the new line.
    always_comb begin
        busy        = state == ACTIVE;
        start_frame = config_done && state == WAIT_FRAME && vsync_fall && start_capture;
        end_frame   = config_done && busy && vsync_rise;
        byte_ok     = config_done && busy && bus.cam_href && bus.cam_byte_valid;
        eff_phase   = href_rise ? 1'b0 : phase;
        eff_col     = href_rise ? '0 : col;
        keep        = byte_ok && eff_phase && !row[0] && !eff_col[0] && eff_col < W_L && row < H_L;
        wr_go       = keep && wr_count != FS_L;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            vsync_q          <= 1'b0;
            href_q           <= 1'b0;
            phase            <= 1'b0;
            ovf              <= 1'b0;
            r_nib            <= '0;
            col              <= '0;
            row              <= '0;
            wr_count         <= '0;
            frame_done       <= 1'b0;
            frame_error      <= 1'b0;
            bus.capture_addr <= '0;
            bus.capture_wren <= 1'b0;
            bus.pixel_out    <= '0;
        end else begin
            vsync_q          <= bus.cam_vsync;
            href_q           <= bus.cam_href;
            frame_done       <= end_frame;
            bus.capture_wren <= wr_go;
            if (end_frame && (wr_count != FS_L || ovf)) frame_error <= 1'b1;
            if (wr_go) bus.pixel_out <= {4'h0, r_nib, bus.cam_data};
            if (start_frame) begin
                phase            <= 1'b0;
                ovf              <= 1'b0;
                col              <= '0;
                row              <= '0;
                wr_count         <= '0;
                bus.capture_addr <= '0;
            end else begin
                if (bus.capture_wren && bus.capture_addr != LAST) bus.capture_addr <= bus.capture_addr + 1'b1;
                if (href_rise) begin
                    phase <= 1'b0;
                    col   <= '0;
                end
                if (byte_ok) begin
                    phase <= ~eff_phase;
                    if (!eff_phase) r_nib <= bus.cam_data[3:0];
                    else if (eff_col != W_L) col <= eff_col + 1'b1;
                end
                if (busy && href_fall && col != '0 && row != H_L) row <= row + 1'b1;
                if (keep) begin
                    if (wr_go) wr_count <= wr_count + 1'b1;
                    else       ovf      <= 1'b1;
                end
            end
        end
    end
endmodule

// File: doc/ov7670_capture_downsampler.md
Name: ov7670_capture_downsampler

Overview:
- Producer side of the capture write interface consumed by the object-detection unit.
- Takes the OV7670 RGB444 byte stream (640x480, two bytes per pixel), already synchronized to clk.
- Assembles pixels and decimates 2:1 in both axes to 320x240.
- Emits capture_addr / capture_wren / pixel_out writes, one per kept pixel, plus frame status.

Parameters:
- SRC_WIDTH, 640, source pixels per line.
- SRC_HEIGHT, 480, source lines per frame.
- FRAME_SIZE, 76800, output pixels per frame (SRC_WIDTH/2 * SRC_HEIGHT/2).
- ADDR_WIDTH, 17, capture_addr width.

Ports:
- clk  in  1  system clock.
- resetn  in  1  asynchronous active-low reset.
- config_done  in  1  camera I2C configuration complete (level).
- start_capture  in  1  enable continuous capture (level).
- cam_vsync  in  1  frame sync, high during vertical blanking.
- cam_href  in  1  line valid.
- cam_byte_valid  in  1  one-cycle strobe, cam_data valid.
- cam_data  in  8  camera byte.
- capture_addr  out  ADDR_WIDTH  BRAM write address.
- capture_wren  out  1  BRAM write strobe, one cycle per pixel.
- pixel_out  out  16  {4'h0, R[3:0], G[3:0], B[3:0]}.
- frame_done  out  1  one-cycle pulse at end of each completed frame.
- frame_error  out  1  sticky; set when a frame ends with write count != FRAME_SIZE.
- busy  out  1  high while in ACTIVE.

Behaviour:
- Reset values: all outputs 0; state WAIT_CFG; counters 0; vsync/href edge registers 0.
- Edges: vsync_fall and href_rise/fall are detected against the previous-cycle sample.
- State machine:
  - WAIT_CFG: leave to WAIT_FRAME when config_done=1.
  - WAIT_FRAME: on vsync_fall with start_capture=1, go to ACTIVE; clear row, col, byte phase and write count; capture_addr<=0.
  - ACTIVE: on vsync rise, go to WAIT_FRAME and pulse frame_done. If write count != FRAME_SIZE, set frame_error in the same cycle.
  - Any state: config_done=0 forces WAIT_CFG next cycle. No frame_done pulse, no further writes; any in-flight write is dropped.
- start_capture deasserted mid-frame: the current frame completes normally; it is only checked at vsync_fall.
- Byte assembly in ACTIVE while cam_href=1 and cam_byte_valid=1:
  - Phase 0 latches R = cam_data[3:0].
  - Phase 1 forms the pixel {G = cam_data[7:4], B = cam_data[3:0]} and increments col.
  - href_rise clears phase and col.
  - href_fall increments row if col>0.
- Decimation: a pixel is kept iff row[0]==0 and col[0]==0, with col counted before its increment.
- Write timing: a kept pixel drives capture_wren=1 with pixel_out the cycle after the phase-1 byte, i.e. 1-cycle latency.
- Address sequence: first write of a frame uses addr 0. capture_addr increments by 1 in the cycle after each write, so consecutive writes are 0,1,2,...
- Address saturation: once the write count reaches FRAME_SIZE, further kept pixels are dropped (no wren) and a count-overflow flag is set. That frame ends with frame_error=1.
- Line length: col beyond SRC_WIDTH-1 is ignored (no writes). Rows beyond SRC_HEIGHT-1 are ignored.
- cam_byte_valid while href=0 is ignored; the phase is not advanced.
- frame_error clears only on reset.
- busy = (state==ACTIVE).

Test Plan:
- Reset and config gating:
  - Stimulus: hold config_done=0, drive a full 640x480 frame.
  - Required: zero wren pulses; all outputs 0.
  - Then raise config_done and start_capture and drive one frame.
  - Required: exactly 76800 wren pulses, addrs 0..76799 in order, one frame_done, frame_error=0.
- Pixel packing and decimation:
  - Stimulus: line 0 bytes 0x0A,0xBC,0x01,0x23,0x05,0x67.
  - Required: writes at addr0 = 0x0ABC and addr1 = 0x0567; no write for 0x0123. Line 1 produces no writes; line 2 first pixel goes to addr 320.
- Short frame:
  - Stimulus: vsync rises after 100 source lines.
  - Required: frame_done pulse, 16000 writes, frame_error=1.
  - Next full frame: addresses restart at 0; frame_error stays 1.
- Long line / extra lines:
  - Stimulus: 700 pixels per line and 500 lines.
  - Required: exactly 76800 writes, last addr 76799, no addr ≥76800, frame_error=0.
- Mid-frame config loss:
  - Stimulus: drop config_done after 5000 writes.
  - Required: no further wren, no frame_done, busy=0 next cycle.
  - Restore config_done: capture resumes at the next vsync_fall from addr 0.
- Async reset mid-line:
  - Stimulus: assert resetn=0 between phase-0 and phase-1 bytes.
  - Required: outputs 0 immediately. After release, the next frame starts cleanly with the first write 0x0XXX at addr 0.
